nw_score_store: RTL and testbench

Parametrised score-matrix storage engine for the Needleman-Wunsch datapath, sitting between the cell-compute unit and the traceback stage. It initialises row 0 and column 0 of the (N+1)x(N+1) score matrix autonomously from a gap penalty. It serves neighbour-fetch requests (diag/up/left) over a valid/ready handshake and accepts cell write-backs. It generalises the earlier fixed-width score manager with configurable score width, internal init generation, request error flagging, and an optional left-neighbour forwarding path.

---
 rtl/nw_score_store_if.sv | 29 ++
 rtl/nw_score_store.sv | 263 ++++++++++++++++++++++++++
 tb/tb_nw_score_store.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nw_score_store_if.sv
// Request/response and write-back bus between the cell-compute unit and the
// Needleman-Wunsch score store.
interface nw_score_store_if #(
  parameter int AW = 8,
  parameter int SW = 9
);
  logic                 req_valid;
  logic                 req_ready;
  logic [AW-1:0]        req_i;
  logic [AW-1:0]        req_j;
  logic                 rsp_valid;
  logic signed [SW-1:0] diag;
  logic signed [SW-1:0] up;
  logic signed [SW-1:0] left;
  logic                 wr_en;
  logic [AW-1:0]        wr_i;
  logic [AW-1:0]        wr_j;
  logic signed [SW-1:0] wr_data;

  modport master (
    output req_valid, req_i, req_j, wr_en, wr_i, wr_j, wr_data,
    input  req_ready, rsp_valid, diag, up, left
  );

  modport slave (
    input  req_valid, req_i, req_j, wr_en, wr_i, wr_j, wr_data,
    output req_ready, rsp_valid, diag, up, left
  );
endinterface

// File: rtl/nw_score_store.sv
// Needleman-Wunsch score-matrix store: border init, diag/up/left fetch, write-back.
// Optional macro SCORE_FWD_EN adds last-write forwarding for the left neighbour.
module nw_score_store #(
  parameter int                   N   = 128,
  parameter int                   SW  = 9,
  parameter logic signed [SW-1:0] GAP = SW'(-2),
  parameter int                   AW  = $clog2(N+1),
  parameter int                   MAW = $clog2((N+1)*(N+1))
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init_start,
  output logic                 init_done,
  output logic signed [SW-1:0] final_score,
  output logic                 err,
  nw_score_store_if.slave      bus
);

  // state   | meaning
  // IDLE    | uninitialised, requests blocked
  // INIT    | writing one border cell per cycle
  // READY   | accepting requests
  // RD_DIAG | capturing diag, up read in flight
  // RD_UP   | capturing up, left read in flight (or forwarded)
  // RD_LEFT | capturing left
  // RSP     | rsp_valid pulse
  typedef enum logic [2:0] {IDLE, INIT, READY, RD_DIAG, RD_UP, RD_LEFT, RSP} state_t;

  localparam int DIM = N + 1;
  localparam int CW  = $clog2(2*N + 1);
  localparam logic signed [SW:0] S_MIN = {2'b11, {(SW-1){1'b0}}};
  localparam logic signed [SW:0] S_MAX = {2'b00, {(SW-1){1'b1}}};

  function automatic logic [MAW-1:0] cell_addr(input logic [AW-1:0] i, input logic [AW-1:0] j);
    return MAW'(i) * MAW'(DIM) + MAW'(j);
  endfunction

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic signed [SW-1:0] acc_q, acc_d;
  logic                 init_done_q, init_done_d;
  logic                 err_q, err_d;
  logic [AW-1:0]        ci_q, ci_d, cj_q, cj_d;
  logic signed [SW-1:0] diag_s_q, diag_s_d, up_s_q, up_s_d;
  logic signed [SW-1:0] diag_q, diag_d, up_q, up_d, left_q, left_d;
  logic signed [SW-1:0] final_q, final_d;
  logic signed [SW-1:0] rd_data_q;
  logic signed [SW-1:0] mem [DIM*DIM];

  logic                 req_ready, req_fire, bad_req;
  logic                 ext_wr_ok;
  logic signed [SW:0]   acc_sum;
  logic signed [SW-1:0] acc_sat;
  logic [CW:0]          k_ext;
  logic [AW-1:0]        init_i, init_j;
  logic                 we;
  logic [MAW-1:0]       waddr, raddr;
  logic signed [SW-1:0] wdata;
  logic                 fwd_hit;
  logic signed [SW-1:0] fwd_val;

  assign req_ready = (state_q == READY) && !init_start;
  assign req_fire  = bus.req_valid && req_ready;
  assign bad_req   = (bus.req_i == '0) || (bus.req_i > AW'(N)) ||
                     (bus.req_j == '0) || (bus.req_j > AW'(N));
  assign ext_wr_ok = bus.wr_en && (state_q != IDLE) && (state_q != INIT) &&
                     (bus.wr_i <= AW'(N)) && (bus.wr_j <= AW'(N));

  // Border walk: cnt 0 -> (0,0), odd cnt -> (0,k), even cnt -> (k,0), k = (cnt+1)/2.
  always_comb begin
    acc_sum = {acc_q[SW-1], acc_q} + {GAP[SW-1], GAP};
    if (acc_sum < S_MIN)      acc_sat = S_MIN[SW-1:0];
    else if (acc_sum > S_MAX) acc_sat = S_MAX[SW-1:0];
    else                      acc_sat = acc_sum[SW-1:0];
    k_ext  = ({1'b0, cnt_q} + (CW+1)'(1)) >> 1;
    init_i = cnt_q[0] ? '0 : k_ext[AW-1:0];
    init_j = cnt_q[0] ? k_ext[AW-1:0] : '0;
  end

  always_comb begin
    we    = (state_q == INIT) || ext_wr_ok;
    waddr = (state_q == INIT) ? cell_addr(init_i, init_j) : cell_addr(bus.wr_i, bus.wr_j);
    wdata = (state_q == INIT) ? (cnt_q[0] ? acc_sat : acc_q) : bus.wr_data;
  end

  // Reads are launched one cycle ahead so each RD_* state sees its own neighbour.
  always_comb begin
    case (state_q)
      RD_DIAG: raddr = cell_addr(ci_q - AW'(1), cj_q);
      RD_UP:   raddr = cell_addr(ci_q, cj_q - AW'(1));
      default: raddr = cell_addr(bus.req_i - AW'(1), bus.req_j - AW'(1));
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rd_data_q <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

`ifdef SCORE_FWD_EN
  logic [AW-1:0]        fi_q, fi_d, fj_q, fj_d;
  logic signed [SW-1:0] fd_q, fd_d;
  logic                 fv_q, fv_d;

  always_comb begin
    fi_d = fi_q;
    fj_d = fj_q;
    fd_d = fd_q;
    fv_d = fv_q;
    if (ext_wr_ok) begin
      fi_d = bus.wr_i;
      fj_d = bus.wr_j;
      fd_d = bus.wr_data;
      fv_d = 1'b1;
    end
    if (init_start) fv_d = 1'b0;
    fwd_hit = 1'b0;
    fwd_val = fd_q;
    if (ext_wr_ok && (bus.wr_i == ci_q) && (bus.wr_j == cj_q - AW'(1))) begin
      fwd_hit = 1'b1;
      fwd_val = bus.wr_data;
    end else if (fv_q && (fi_q == ci_q) && (fj_q == cj_q - AW'(1))) begin
      fwd_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fi_q <= '0;
      fj_q <= '0;
      fd_q <= '0;
      fv_q <= 1'b0;
    end else begin
      fi_q <= fi_d;
      fj_q <= fj_d;
      fd_q <= fd_d;
      fv_q <= fv_d;
    end
  end
`else
  assign fwd_hit = 1'b0;
  assign fwd_val = '0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    init_done_d = init_done_q;
    err_d       = 1'b0;
    ci_d        = ci_q;
    cj_d        = cj_q;
    diag_s_d    = diag_s_q;
    up_s_d      = up_s_q;
    diag_d      = diag_q;
    up_d        = up_q;
    left_d      = left_q;
    final_d     = final_q;

    if (bus.wr_en && ((state_q == IDLE) || (state_q == INIT))) err_d = 1'b1;
    if (ext_wr_ok && (bus.wr_i == AW'(N)) && (bus.wr_j == AW'(N))) final_d = bus.wr_data;

    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d     = INIT;
          cnt_d       = '0;
          acc_d       = '0;
          init_done_d = 1'b0;
        end
      end
      INIT: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q[0]) acc_d = acc_sat;
        if (cnt_q == CW'(2*N)) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end
      end
      READY: begin
        if (init_start) begin
          state_d     = INIT;
          cnt_d       = '0;
          acc_d       = '0;
          init_done_d = 1'b0;
        end else if (req_fire) begin
          if (bad_req) begin
            err_d = 1'b1;
          end else begin
            ci_d    = bus.req_i;
            cj_d    = bus.req_j;
            state_d = RD_DIAG;
          end
        end
      end
      RD_DIAG: begin
        diag_s_d = rd_data_q;
        state_d  = RD_UP;
      end
      RD_UP: begin
        up_s_d = rd_data_q;
        if (fwd_hit) begin
          diag_d  = diag_s_q;
          up_d    = rd_data_q;
          left_d  = fwd_val;
          state_d = RSP;
        end else begin
          state_d = RD_LEFT;
        end
      end
      RD_LEFT: begin
        diag_d  = diag_s_q;
        up_d    = up_s_q;
        left_d  = rd_data_q;
        state_d = RSP;
      end
      RSP:     state_d = READY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      ci_q        <= '0;
      cj_q        <= '0;
      diag_s_q    <= '0;
      up_s_q      <= '0;
      diag_q      <= '0;
      up_q        <= '0;
      left_q      <= '0;
      final_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      ci_q        <= ci_d;
      cj_q        <= cj_d;
      diag_s_q    <= diag_s_d;
      up_s_q      <= up_s_d;
      diag_q      <= diag_d;
      up_q        <= up_d;
      left_q      <= left_d;
      final_q     <= final_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state_q == RSP);
  assign bus.diag      = diag_q;
  assign bus.up        = up_q;
  assign bus.left      = left_q;
  assign init_done     = init_done_q;
  assign err           = err_q;
  assign final_score   = final_q;

endmodule

// File: tb/tb_nw_score_store.sv
// Scoreboard bench for nw_score_store (N=4, SW=9, GAP=-2): directed requests
// push expected neighbours; a negedge monitor pops and compares on rsp_valid.
module tb_nw_score_store;
  localparam int N  = 4;
  localparam int SW = 9;
  localparam int AW = 3;
`ifdef SCORE_FWD_EN
  localparam int FWD_LAT = 3;
`else
  localparam int FWD_LAT = 4;
`endif

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 init_start = 1'b0;
  logic                 init_done;
  logic                 err;
  logic signed [SW-1:0] final_score;

  nw_score_store_if #(.AW(AW), .SW(SW)) bus ();

  nw_score_store #(.N(N), .SW(SW), .GAP(-9'sd2), .AW(AW), .MAW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .init_start  (init_start),
    .init_done   (init_done),
    .final_score (final_score),
    .err         (err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic signed [SW-1:0] d;
    logic signed [SW-1:0] u;
    logic signed [SW-1:0] l;
    int                   due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   err_seen = 0;

  function automatic void check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (err) err_seen++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 1, 0);
        end else begin
          e = sb.pop_front();
          check("rsp_diag", int'(bus.diag), int'(e.d));
          check("rsp_up", int'(bus.up), int'(e.u));
          check("rsp_left", int'(bus.left), int'(e.l));
          check("rsp_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_cell(input int i, input int j, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_i    = AW'(i);
    bus.wr_j    = AW'(j);
    bus.wr_data = SW'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Returns in the cycle after the accept edge; lat counts cycles from accept to rsp.
  task automatic send_req(input int i, input int j, input bit push,
                          input int d, input int u, input int l, input int lat);
    int   n;
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_i     = AW'(i);
    bus.req_j     = AW'(j);
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 0, 1);
    end else if (push) begin
      e.d   = SW'(d);
      e.u   = SW'(u);
      e.l   = SW'(l);
      e.due = cyc + lat;
      sb.push_back(e);
    end
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      check("rsp_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_init(input bit inject_wr, input bit with_req);
    int p;
    int n;
    init_start = 1'b1;
    if (with_req) begin
      bus.req_valid = 1'b1;
      bus.req_i     = AW'(1);
      bus.req_j     = AW'(1);
      #1;
      check("init_beats_req_ready", int'(bus.req_ready), 0);
    end
    p = cyc;
    tick();
    init_start    = 1'b0;
    bus.req_valid = 1'b0;
    check("init_done_cleared", int'(init_done), 0);
    n = 0;
    while (!init_done && n < 40) begin
      if (inject_wr && n == 3) begin
        bus.wr_en   = 1'b1;
        bus.wr_i    = AW'(0);
        bus.wr_j    = AW'(1);
        bus.wr_data = SW'(55);
      end
      if (n == 4) bus.wr_en = 1'b0;
      tick();
      n++;
    end
    bus.wr_en = 1'b0;
    // init_start launched at p, sampled at edge p+1; init_done seen in cycle 2N+2 after that
    check("init_done_cycle", cyc - p, 2*N + 2);
  endtask

  initial begin
    int e0;
    bus.req_valid = 1'b0;
    bus.req_i     = '0;
    bus.req_j     = '0;
    bus.wr_en     = 1'b0;
    bus.wr_i      = '0;
    bus.wr_j      = '0;
    bus.wr_data   = '0;
    #1 rst = 1'b0;
    repeat (3) tick();
    check("rst_init_done", int'(init_done), 0);
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_rsp_valid", int'(bus.rsp_valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_diag", int'(bus.diag), 0);
    check("rst_final", int'(final_score), 0);
    rst = 1'b1;
    tick();
    check("idle_req_ready", int'(bus.req_ready), 0);

    e0 = err_seen;
    wr_cell(1, 1, 33);
    tick();
    check("err_idle_wr", err_seen - e0, 1);

    e0 = err_seen;
    do_init(1'b1, 1'b0);
    tick();
    check("err_init_wr", err_seen - e0, 1);
    check("ready_after_init", int'(bus.req_ready), 1);

    send_req(1, 1, 1'b1, 0, -2, -2, 4);
    wait_idle();

    wr_cell(1, 1, 1);
    send_req(1, 2, 1'b1, -2, -4, 1, FWD_LAT);
    wait_idle();

    send_req(2, 1, 1'b1, -2, 1, -4, 4);
    check("busy_req_ready", int'(bus.req_ready), 0);
    wr_cell(4, 4, 7);
    check("final_score", int'(final_score), 7);
    wait_idle();

    e0 = err_seen;
    send_req(0, 3, 1'b0, 0, 0, 0, 0);
    check("ready_after_bad", int'(bus.req_ready), 1);
    send_req(5, 1, 1'b0, 0, 0, 0, 0);
    tick();
    check("err_bad_req", err_seen - e0, 2);
    check("ready_after_bad2", int'(bus.req_ready), 1);

    wr_cell(2, 1, 4);
    wr_cell(1, 2, 3);
    bus.wr_en   = 1'b1;
    bus.wr_i    = AW'(1);
    bus.wr_j    = AW'(1);
    bus.wr_data = SW'(9);
    send_req(2, 2, 1'b1, 9, 3, 4, 4);
    bus.wr_en = 1'b0;
    send_req(2, 2, 1'b1, 9, 3, 4, 4);
    wait_idle();

    send_req(1, 3, 1'b1, -4, -6, 6, FWD_LAT);
    tick();
    wr_cell(1, 2, 6);
    wait_idle();

    do_init(1'b0, 1'b1);
    repeat (3) tick();

    send_req(1, 1, 1'b0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_diag", int'(bus.diag), 0);
    check("midrst_up", int'(bus.up), 0);
    check("midrst_left", int'(bus.left), 0);
    check("midrst_final", int'(final_score), 0);
    check("midrst_init_done", int'(init_done), 0);
    check("midrst_req_ready", int'(bus.req_ready), 0);
    check("midrst_rsp_valid", int'(bus.rsp_valid), 0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("post_rst_idle_ready", int'(bus.req_ready), 0);
    do_init(1'b0, 1'b0);
    send_req(1, 2, 1'b1, -2, -4, 9, 4);
    wait_idle();

    repeat (3) tick();
    if (sb.size() != 0) check("pending_rsp", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
